// File: rtl/hazard_forward_unit.sv
// Hazard and bypass controller for the in-order pipeline D, X, M1..Mk, W.
// Tracks in-flight register writers in a per-stage shift pipeline, raises the
// load-use stall for the instruction in D and registers the per-source bypass
// selects that the datapath applies while that instruction sits in X.
//
// Issue semantics: the instruction in D moves into X on a clock edge exactly
// when issue_valid=1, stall=0 and flush=0. In every other cycle a bubble
// enters X and fwd_valid/fwd_sel load zero.
module hazard_forward_unit #(
    parameter int NUM_SRC    = 2,
    parameter int MEM_STAGES = 1,
    parameter int CNT_W      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [NUM_SRC*5-1:0] issue_src,
    input  logic [NUM_SRC-1:0]   issue_src_used,
    input  logic [4:0]           issue_dst,
    input  logic                 issue_rwe,
    input  logic                 issue_is_load,
    input  logic                 flush,
    output logic                 stall,
    output logic [NUM_SRC*3-1:0] fwd_sel,
    output logic                 fwd_valid,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    // X=1, M1..Mk=2..DEPTH-1, W=DEPTH. The W entry is never a bypass source
    // (the register file is write-before-read), so only 1..LAST are stored.
    localparam int DEPTH = MEM_STAGES + 2;
    localparam int LAST  = DEPTH - 1;

    logic [LAST:1]        st_v;
    logic [LAST:1]        st_rwe;
    logic [LAST:1]        st_ld;
    logic [4:0]           st_dst [1:LAST];

    logic [NUM_SRC*3-1:0] sel_c;
    logic [NUM_SRC-1:0]   hz_c;
    logic                 issue_go;

    // Youngest-match search per source port: scanning from the oldest stage
    // towards X lets the youngest matching writer overwrite older ones.
    always_comb begin
        sel_c = '0;
        hz_c  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = LAST; s >= 1; s--) begin
                if (issue_src_used[i] && (issue_src[5*i +: 5] != 5'd0) &&
                    st_v[s] && st_rwe[s] && (st_dst[s] == issue_src[5*i +: 5])) begin
                    // Producer in stage s will be in stage s+1 when the consumer is in X.
                    sel_c[3*i +: 3] = 3'(s + 1);
                    // Load data exists only once the load reaches the last memory stage.
                    hz_c[i]         = st_ld[s] && (s <= DEPTH - 2);
                end
            end
        end
    end

    // Stall and issue qualification; a flush squashes D and overrides any hazard.
    always_comb begin
        stall    = issue_valid && !flush && (|hz_c);
        issue_go = issue_valid && !stall && !flush;
    end

    // Writer-tracking shift pipeline: X takes the issued tuple or a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_v   <= '0;
            st_rwe <= '0;
            st_ld  <= '0;
            for (int s = 1; s <= LAST; s++) begin
                st_dst[s] <= 5'd0;
            end
        end else begin
            st_v[1]   <= issue_go;
            st_rwe[1] <= issue_go && issue_rwe;
            st_ld[1]  <= issue_go && issue_is_load;
            st_dst[1] <= issue_dst;
            for (int s = 2; s <= LAST; s++) begin
                st_v[s]   <= st_v[s-1];
                st_rwe[s] <= st_rwe[s-1];
                st_ld[s]  <= st_ld[s-1];
                st_dst[s] <= st_dst[s-1];
            end
        end
    end

    // Bypass selects registered for the instruction entering X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_sel   <= '0;
            fwd_valid <= 1'b0;
        end else if (issue_go) begin
            fwd_sel   <= sel_c;
            fwd_valid <= 1'b1;
        end else begin
            fwd_sel   <= '0;
            fwd_valid <= 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush && issue_valid && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: one instance with MEM_STAGES=1 and a 4-bit
// counter width (k=0), one with MEM_STAGES=3 and 32-bit counters (k=1).
// Directed vector table, a reset-mid-stall sequence, then random stimulus
// checked against an issue-history model.
module tb_hazard_forward_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic       iv    [2];
  logic [9:0] isrc  [2];
  logic [1:0] iused [2];
  logic [4:0] idst  [2];
  logic       irwe  [2];
  logic       ild   [2];
  logic       ifl   [2];
  logic       st_o  [2];
  logic [5:0] sel_o [2];
  logic       fv_o  [2];
  logic [3:0]  sc0, fc0;
  logic [31:0] sc1, fc1;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit #(.NUM_SRC(2), .MEM_STAGES(1), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .issue_valid(iv[0]), .issue_src(isrc[0]),
    .issue_src_used(iused[0]), .issue_dst(idst[0]), .issue_rwe(irwe[0]),
    .issue_is_load(ild[0]), .flush(ifl[0]), .stall(st_o[0]), .fwd_sel(sel_o[0]),
    .fwd_valid(fv_o[0]), .stall_cycles(sc0), .flush_count(fc0)
  );

  hazard_forward_unit #(.NUM_SRC(2), .MEM_STAGES(3), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .issue_valid(iv[1]), .issue_src(isrc[1]),
    .issue_src_used(iused[1]), .issue_dst(idst[1]), .issue_rwe(irwe[1]),
    .issue_is_load(ild[1]), .flush(ifl[1]), .stall(st_o[1]), .fwd_sel(sel_o[1]),
    .fwd_valid(fv_o[1]), .stall_cycles(sc1), .flush_count(fc1)
  );

  // ---------------- reference model: history of issued instructions ----------------
  typedef struct {
    int         c;     // cycle in which it issued (entered X at the following edge)
    logic [4:0] dst;
    logic       rwe;
    logic       ld;
  } ent_t;

  ent_t       hq0[$];
  ent_t       hq1[$];
  int         now = 0;
  logic [5:0] m_sel [2];
  logic       m_fv  [2];
  longint     m_sc  [2];
  longint     m_fc  [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 3 : 5;
  endfunction

  // A writer that issued in cycle c sits in stage (now - c) this cycle.
  function automatic void mdl_eval(input int k, output logic st, output logic [5:0] sel);
    int   d;
    int   n;
    int   age;
    logic hz;
    logic found;
    logic [4:0] src;
    ent_t e;
    d   = depth_of(k);
    n   = (k == 0) ? hq0.size() : hq1.size();
    hz  = 1'b0;
    sel = 6'd0;
    for (int p = 0; p < 2; p++) begin
      src   = isrc[k][5*p +: 5];
      found = 1'b0;
      if (iused[k][p] && src != 5'd0) begin
        for (int j = 0; j < n; j++) begin
          e   = (k == 0) ? hq0[j] : hq1[j];
          age = now - e.c;
          if (!found && age >= 1 && age <= d - 1 && e.rwe && e.dst == src) begin
            found = 1'b1;
            sel[3*p +: 3] = 3'(age + 1);
            if (e.ld && age <= d - 2) hz = 1'b1;
          end
        end
      end
    end
    st = iv[k] && !ifl[k] && hz;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hq0.delete();
      hq1.delete();
      for (int k = 0; k < 2; k++) begin
        m_sel[k] <= 6'd0;
        m_fv[k]  <= 1'b0;
        m_sc[k]  <= 0;
        m_fc[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic       st;
        logic [5:0] sel;
        logic       go;
        longint     mx;
        ent_t       e;
        mdl_eval(k, st, sel);
        go = iv[k] && !st && !ifl[k];
        if (go) begin
          e.c = now; e.dst = idst[k]; e.rwe = irwe[k]; e.ld = ild[k];
          if (k == 0) hq0.push_front(e); else hq1.push_front(e);
        end
        while (hq0.size() > 8) void'(hq0.pop_back());
        while (hq1.size() > 8) void'(hq1.pop_back());
        m_sel[k] <= go ? sel : 6'd0;
        m_fv[k]  <= go;
        mx = (k == 0) ? 64'd15 : 64'hFFFF_FFFF;
        if (st && m_sc[k] < mx) m_sc[k] <= m_sc[k] + 1;
        if (iv[k] && ifl[k] && m_fc[k] < mx) m_fc[k] <= m_fc[k] + 1;
      end
      now <= now + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0d expected=%0d", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sc_of(input int k);
    return (k == 0) ? 32'(sc0) : sc1;
  endfunction

  function automatic logic [31:0] fc_of(input int k);
    return (k == 0) ? 32'(fc0) : fc1;
  endfunction

  task automatic check_model();
    logic       st;
    logic [5:0] sel;
    for (int k = 0; k < 2; k++) begin
      mdl_eval(k, st, sel);
      chk("rnd_stall", k, 32'(st_o[k]), 32'(st));
      chk("rnd_fwd_sel", k, 32'(sel_o[k]), 32'(m_sel[k]));
      chk("rnd_fwd_valid", k, 32'(fv_o[k]), 32'(m_fv[k]));
      chk("rnd_stall_cycles", k, sc_of(k), 32'(m_sc[k]));
      chk("rnd_flush_count", k, fc_of(k), 32'(m_fc[k]));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int k, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] u, input logic [4:0] d, input logic rwe,
                       input logic ld, input logic fl);
    iv[k] = v; isrc[k] = {s1, s0}; iused[k] = u; idst[k] = d;
    irwe[k] = rwe; ild[k] = ld; ifl[k] = fl;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(0);
    idle(1);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       rst;
    int       k;
    bit       v;
    bit [4:0] s0, s1;
    bit [1:0] u;
    bit [4:0] d;
    bit       rwe, ld, fl;
    bit       e_st;
    bit [2:0] e0, e1;
    bit       e_fv;
    int       e_sc, e_fc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input int k, input bit v, input bit [4:0] s0, input bit [4:0] s1,
                     input bit [1:0] u, input bit [4:0] d, input bit rwe, input bit ld, input bit fl,
                     input bit e_st, input bit [2:0] e0, input bit [2:0] e1, input bit e_fv,
                     input int e_sc, input int e_fc);
    vec_t r;
    r.rst = rst; r.k = k; r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.d = d;
    r.rwe = rwe; r.ld = ld; r.fl = fl; r.e_st = e_st; r.e0 = e0; r.e1 = e1;
    r.e_fv = e_fv; r.e_sc = e_sc; r.e_fc = e_fc;
    tbl.push_back(r);
  endtask

  initial begin
    reset = 1'b1;
    idle(0);
    idle(1);

    // ADD r3 ; ADD r4,r3,r3 (MX on both ports)
    add(1,0, 1, 1,2, 2'b11, 3, 1,0,0,  0, 0,0, 0, 0,0);
    add(0,0, 1, 3,3, 2'b11, 4, 1,0,0,  0, 0,0, 1, 0,0);
    add(0,0, 0, 0,0, 2'b00, 0, 0,0,0,  0, 2,2, 1, 0,0);
    // LW r5 ; ADD r6,r5,r0 with one memory stage: one stall, then WX
    add(1,0, 1, 1,0, 2'b01, 5, 1,1,0,  0, 0,0, 0, 0,0);
    add(0,0, 1, 5,0, 2'b11, 6, 1,0,0,  1, 0,0, 1, 0,0);
    add(0,0, 1, 5,0, 2'b11, 6, 1,0,0,  0, 0,0, 0, 1,0);
    add(0,0, 0, 0,0, 2'b00, 0, 0,0,0,  0, 3,0, 1, 1,0);
    // LW r7 ; SUB r8,r7,r1 with three memory stages: three stalls, then sel 5
    add(1,1, 1, 1,0, 2'b01, 7, 1,1,0,  0, 0,0, 0, 0,0);
    add(0,1, 1, 7,1, 2'b11, 8, 1,0,0,  1, 0,0, 1, 0,0);
    add(0,1, 1, 7,1, 2'b11, 8, 1,0,0,  1, 0,0, 0, 1,0);
    add(0,1, 1, 7,1, 2'b11, 8, 1,0,0,  1, 0,0, 0, 2,0);
    add(0,1, 1, 7,1, 2'b11, 8, 1,0,0,  0, 0,0, 0, 3,0);
    add(0,1, 0, 0,0, 2'b00, 0, 0,0,0,  0, 5,0, 1, 3,0);
    // LW r9 ; ADD r9 ; OR r10,r9 -> younger ADD shadows the load
    add(1,0, 1, 1,0, 2'b01, 9, 1,1,0,  0, 0,0, 0, 0,0);
    add(0,0, 1, 1,2, 2'b11, 9, 1,0,0,  0, 0,0, 1, 0,0);
    add(0,0, 1, 9,0, 2'b01,10, 1,0,0,  0, 0,0, 1, 0,0);
    add(0,0, 0, 0,0, 2'b00, 0, 0,0,0,  0, 2,0, 1, 0,0);
    // LW r2 ; consumer flushed, then reissued one stage later (two stalls)
    add(1,1, 1, 1,0, 2'b01, 2, 1,1,0,  0, 0,0, 0, 0,0);
    add(0,1, 1, 2,2, 2'b11,11, 1,0,1,  0, 0,0, 1, 0,0);
    add(0,1, 1, 2,2, 2'b11,11, 1,0,0,  1, 0,0, 0, 0,1);
    add(0,1, 1, 2,2, 2'b11,11, 1,0,0,  1, 0,0, 0, 1,1);
    add(0,1, 1, 2,2, 2'b11,11, 1,0,0,  0, 0,0, 0, 2,1);
    add(0,1, 0, 0,0, 2'b00, 0, 0,0,0,  0, 5,5, 1, 2,1);
    // writers of r0 never forward and never stall
    add(1,0, 1, 0,0, 2'b11, 0, 1,1,0,  0, 0,0, 0, 0,0);
    add(0,0, 1, 0,0, 2'b11, 0, 1,1,0,  0, 0,0, 1, 0,0);
    add(0,0, 1, 0,0, 2'b11, 5, 1,0,0,  0, 0,0, 1, 0,0);
    add(0,0, 0, 0,0, 2'b00, 0, 0,0,0,  0, 0,0, 1, 0,0);

    @(posedge clock);
    #1;
    foreach (tbl[n]) begin
      if (tbl[n].rst) do_reset();
      idle(1 - tbl[n].k);
      drive(tbl[n].k, tbl[n].v, tbl[n].s0, tbl[n].s1, tbl[n].u, tbl[n].d,
            tbl[n].rwe, tbl[n].ld, tbl[n].fl);
      @(negedge clock);
      chk("vec_stall", tbl[n].k, 32'(st_o[tbl[n].k]), 32'(tbl[n].e_st));
      chk("vec_fwd_sel", tbl[n].k, 32'(sel_o[tbl[n].k]), 32'({tbl[n].e1, tbl[n].e0}));
      chk("vec_fwd_valid", tbl[n].k, 32'(fv_o[tbl[n].k]), 32'(tbl[n].e_fv));
      chk("vec_stall_cycles", tbl[n].k, sc_of(tbl[n].k), 32'(tbl[n].e_sc));
      chk("vec_flush_count", tbl[n].k, fc_of(tbl[n].k), 32'(tbl[n].e_fc));
      @(posedge clock);
      #1;
    end

    // Reset asserted in the second cycle of a three-cycle load-use stall
    do_reset();
    drive(1, 1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    drive(1, 1'b1, 5'd7, 5'd1, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    chk("mid_stall_c1", 1, 32'(st_o[1]), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mid_stall_c2", 1, 32'(st_o[1]), 32'd1);
    chk("mid_stall_cnt", 1, sc1, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_stall_drop", 1, 32'(st_o[1]), 32'd0);
    chk("rst_fwd_sel", 1, 32'(sel_o[1]), 32'd0);
    chk("rst_fwd_valid", 1, 32'(fv_o[1]), 32'd0);
    chk("rst_stall_cycles", 1, sc1, 32'd0);
    chk("rst_flush_count", 1, fc1, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_stall", 1, 32'(st_o[1]), 32'd0);
    @(posedge clock);
    #1 idle(1);
    @(negedge clock);
    chk("post_rst_issue_fv", 1, 32'(fv_o[1]), 32'd1);
    chk("post_rst_issue_sel", 1, 32'(sel_o[1]), 32'd0);

    // Random stimulus against the model, both configurations at once
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0);
      end
      @(negedge clock);
      check_model();
      @(posedge clock);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
